test_block: RTL and testbench



---
 rtl/test_block_pkg.sv | 15 +
 rtl/test_block_delay.sv | 28 ++
 rtl/test_block.sv | 73 +++++++
 tb/tb_test_block.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/test_block_pkg.sv
// Shared definitions for the test_block programmable logic cell.
package test_block_pkg;

  localparam int unsigned MODE_W    = 2;
  localparam int unsigned DELAY_MAX = 3;
  localparam int unsigned SEL_W     = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_BUF    = 2'd0,
    MODE_INV    = 2'd1,
    MODE_RISE   = 2'd2,
    MODE_TOGGLE = 2'd3
  } mode_e;

endpackage

// File: rtl/test_block_delay.sv
// Three-stage shift register with a live-selected tap feeding a registered output.
module test_block_delay
  import test_block_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             din,
  input  logic [SEL_W-1:0] sel,
  output logic             dout
);

  logic [DELAY_MAX-1:0] d_q;
  logic [DELAY_MAX:0]   taps_c;

  // tap0 is the undelayed core value; tapN is N stages behind it
  assign taps_c = {d_q, din};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      d_q  <= '0;
      dout <= 1'b0;
    end else begin
      d_q  <= {d_q[DELAY_MAX-2:0], din};
      dout <= taps_c[sel];
    end
  end

endmodule

// File: rtl/test_block.sv
// Single-bit programmable logic cell: buffer/invert/rise-pulse/toggle, then 0-3 cycle delay.
module test_block
  import test_block_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] FUNC,
  input  logic        FUNC_wstb,
  input  logic [1:0]  A,
  input  logic        INPA_i,
  output logic        OUT_o
);

  mode_e func_reg;
  logic  prev_q;
  logic  tgl_q;
  logic  c_q;

  logic  rise_c;
  logic  tgl_nxt_c;
  logic  c_nxt_c;
  logic  unused_func;

  assign unused_func = ^FUNC[31:MODE_W];
  assign rise_c      = INPA_i & ~prev_q;

  // Core function; the strobe clears tgl and c so a new mode starts from a known state
  always_comb begin
    tgl_nxt_c = tgl_q;
    c_nxt_c   = 1'b0;
    if (FUNC_wstb) begin
      tgl_nxt_c = 1'b0;
      c_nxt_c   = 1'b0;
    end else begin
      case (func_reg)
        MODE_BUF:    c_nxt_c = INPA_i;
        MODE_INV:    c_nxt_c = ~INPA_i;
        MODE_RISE:   c_nxt_c = rise_c;
        MODE_TOGGLE: begin
          tgl_nxt_c = tgl_q ^ rise_c;
          c_nxt_c   = tgl_q ^ rise_c;
        end
        default:     c_nxt_c = 1'b0;
      endcase
    end
  end

  // prev tracks INPA_i regardless of the strobe so no false edge is seen
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      func_reg <= MODE_BUF;
      prev_q   <= 1'b0;
      tgl_q    <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      if (FUNC_wstb) begin
        func_reg <= mode_e'(FUNC[MODE_W-1:0]);
      end
      prev_q <= INPA_i;
      tgl_q  <= tgl_nxt_c;
      c_q    <= c_nxt_c;
    end
  end

  test_block_delay u_delay (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .din     (c_q),
    .sel     (A),
    .dout    (OUT_o)
  );

endmodule

// File: tb/tb_test_block.sv
// Directed bench for test_block with a per-cycle behavioural reference model.
module tb_test_block;

  logic        clk_i;
  logic        rst_n_i;
  logic [31:0] FUNC;
  logic        FUNC_wstb;
  logic [1:0]  A;
  logic        INPA_i;
  logic        OUT_o;

  int n_tests;
  int n_fail;

  test_block dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .FUNC      (FUNC),
    .FUNC_wstb (FUNC_wstb),
    .A         (A),
    .INPA_i    (INPA_i),
    .OUT_o     (OUT_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model: history of core results, newest first; output picks entry A
  int   m_mode;
  bit   m_prev;
  bit   m_tgl;
  bit   m_hist [4];
  bit   exp_out;
  bit   model_live;

  initial begin
    m_mode = 0; m_prev = 0; m_tgl = 0; exp_out = 0; model_live = 0;
    for (int i = 0; i < 4; i++) m_hist[i] = 0;
  end

  always @(negedge rst_n_i) begin
    m_mode = 0; m_prev = 0; m_tgl = 0; exp_out = 0;
    for (int i = 0; i < 4; i++) m_hist[i] = 0;
  end

  always @(posedge clk_i) begin
    bit newc;
    bit rise;
    if (rst_n_i) begin
      exp_out = m_hist[int'(A)];
      rise = INPA_i && !m_prev;
      newc = 0;
      if (FUNC_wstb) begin
        m_mode = int'(FUNC & 32'h3);
        m_tgl  = 0;
        newc   = 0;
      end else begin
        if (m_mode == 0) newc = INPA_i;
        else if (m_mode == 1) newc = !INPA_i;
        else if (m_mode == 2) newc = rise;
        else begin
          if (rise) m_tgl = !m_tgl;
          newc = m_tgl;
        end
      end
      m_prev = INPA_i;
      for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = newc;
    end
  end

  task automatic check(input string name, input logic got, input logic want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: OUT_o=%b expected=%b at t=%0t", name, got, want, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk_i) begin
    if (rst_n_i && model_live) check("model", OUT_o, exp_out);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic strobe(input logic [31:0] f);
    FUNC = f; FUNC_wstb = 1'b1;
    tick(1);
    FUNC_wstb = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n_i = 1'b0; FUNC = '0; FUNC_wstb = 1'b0; A = 2'd0; INPA_i = 1'b0;
    tick(3);
    check("reset_out", OUT_o, 1'b0);
    rst_n_i = 1'b1;
    model_live = 1;
    tick(2);

    // BUF, A=0: sampled edge -> output one edge later
    INPA_i = 1'b1;
    tick(1); check("buf_rise_lat0", OUT_o, 1'b0);
    tick(1); check("buf_rise_lat1", OUT_o, 1'b1);
    tick(5);
    INPA_i = 1'b0;
    tick(1); check("buf_fall_lat0", OUT_o, 1'b1);
    tick(1); check("buf_fall_lat1", OUT_o, 1'b0);

    // INV, A=2
    A = 2'd2;
    strobe(32'd1);
    tick(6); check("inv_settle", OUT_o, 1'b1);
    INPA_i = 1'b1;
    tick(3); check("inv_before", OUT_o, 1'b1);
    tick(1); check("inv_after", OUT_o, 1'b0);
    INPA_i = 1'b0;
    tick(6);

    // RISE, A=0: single-cycle pulse on a 5-cycle high input
    A = 2'd0;
    strobe(32'd2);
    tick(3);
    INPA_i = 1'b1;
    tick(1); check("rise_pre", OUT_o, 1'b0);
    tick(1); check("rise_pulse", OUT_o, 1'b1);
    tick(1); check("rise_end", OUT_o, 1'b0);
    tick(2); check("rise_held", OUT_o, 1'b0);
    INPA_i = 1'b0;
    tick(3);

    // TOGGLE via upper-bits-set value, held-high input flips only once
    strobe(32'h7FFF_FFFF);
    tick(2);
    INPA_i = 1'b1; tick(4); INPA_i = 1'b0; tick(2);
    check("tgl_first", OUT_o, 1'b1);
    INPA_i = 1'b1; tick(1); INPA_i = 1'b0; tick(2);
    check("tgl_second", OUT_o, 1'b0);
    INPA_i = 1'b1; tick(1); INPA_i = 1'b0; tick(3);
    check("tgl_third", OUT_o, 1'b1);
    A = 2'd1;
    tick(3);
    FUNC = 32'd3; FUNC_wstb = 1'b1;
    tick(1); FUNC_wstb = 1'b0;
    check("tgl_clr_k", OUT_o, 1'b1);
    tick(1); check("tgl_clr_k1", OUT_o, 1'b1);
    tick(1); check("tgl_clr_k2", OUT_o, 1'b0);

    // Strobe coincident with a rising edge: no toggle
    A = 2'd0;
    tick(2);
    INPA_i = 1'b1; FUNC = 32'd3; FUNC_wstb = 1'b1;
    tick(1); FUNC_wstb = 1'b0;
    tick(3); check("strobe_edge_clear", OUT_o, 1'b0);
    INPA_i = 1'b0;
    tick(2);

    // A sweep in BUF mode with a counter-derived input
    strobe(32'd0);
    for (int i = 0; i < 48; i++) begin
      logic [5:0] cnt;
      cnt = 6'(i);
      INPA_i = cnt[1] ^ cnt[3];
      if (i < 8) A = 2'd0;
      else if (i < 16) A = 2'd1;
      else if (i < 24) A = 2'd2;
      else if (i < 32) A = 2'd3;
      else if (i < 40) A = 2'd1;
      else A = 2'(i);
      tick(1);
    end
    A = 2'd0; INPA_i = 1'b0;
    tick(4);

    // Async reset mid-TOGGLE, then BUF behaviour after release
    strobe(32'd3);
    tick(1);
    INPA_i = 1'b1; tick(1); INPA_i = 1'b0; tick(3);
    check("pre_reset_tgl", OUT_o, 1'b1);
    #2 rst_n_i = 1'b0;
    #1 check("async_reset", OUT_o, 1'b0);
    #1 rst_n_i = 1'b1;
    tick(2);
    INPA_i = 1'b1;
    tick(2); check("post_reset_buf_hi", OUT_o, 1'b1);
    INPA_i = 1'b0;
    tick(2); check("post_reset_buf_lo", OUT_o, 1'b0);
    tick(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
